// File: rtl/controlador_motores_pkg.sv
// Shared types for the two-motor start/stop controller: FSM state codes, mode
// constants and a constant helper for counter sizing.
package controlador_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        ESCALON = 2'd1,
        MARCHA  = 2'd2,
        ENFRIA  = 2'd3
    } estado_e;

    localparam logic MODO_ALTERNO = 1'b0;
    localparam logic MODO_DUAL    = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/controlador_motores_if.sv
// Run request / motor enable bundle between the stimulus side (master) and the
// controller (slave).
interface controlador_motores_if;

    logic       arranque;
    logic       modo;
    logic       motor1;
    logic       motor2;
    logic       ocupado;
    logic [1:0] estado;

    modport master (
        output arranque,
        output modo,
        input  motor1,
        input  motor2,
        input  ocupado,
        input  estado
    );

    modport slave (
        input  arranque,
        input  modo,
        output motor1,
        output motor2,
        output ocupado,
        output estado
    );

endinterface

// File: rtl/controlador_motores_detector_flanco.sv
// Registered rising-edge detector. A rise is only reported once the input has
// been seen low after reset, so a level already high at reset release is ignored.
module detector_flanco (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic armado_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b0;
            armado_q <= 1'b0;
        end else begin
            prev_q   <= d;
            armado_q <= armado_q | ~d;
        end
    end

    assign rise = d & ~prev_q & armado_q;

endmodule

// File: rtl/controlador_motores.sv
// Two-motor start/stop controller: alternating or staggered dual start, with a
// mandatory cool-down after every stop. Optional run limit under MARCHA_MAX_EN.
module controlador_motores
    import controlador_pkg::*;
#(
    parameter int unsigned T_ESCALON = 4,
    parameter int unsigned T_ENFRIA  = 8,
    parameter int unsigned T_MAX     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    controlador_motores_if.slave bus
);

    localparam int unsigned CW = $clog2(max3(T_ESCALON, T_ENFRIA, T_MAX) + 1);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t ESC_FIN = cnt_t'(T_ESCALON - 1);
    localparam cnt_t ENF_FIN = cnt_t'(T_ENFRIA - 1);

    estado_e state_q;
    cnt_t    cnt_q;
    logic    motor1_q;
    logic    motor2_q;
    logic    ocupado_q;
    logic    turno_q;
    logic    modo_q;
    logic    rise;
    logic    limite;
    logic    parar;

    detector_flanco u_flanco (
        .clk  (clk),
        .rst  (rst),
        .d    (bus.arranque),
        .rise (rise)
    );

    function automatic cnt_t inc_sat(input cnt_t v);
        return (v == '1) ? v : v + cnt_t'(1);
    endfunction

`ifdef MARCHA_MAX_EN
    localparam cnt_t RUN_FIN = cnt_t'(T_MAX);
    cnt_t run_q;

    // Run counter is 1 after the start edge, so the stop lands exactly T_MAX edges later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q <= '0;
        end else if (state_q == REPOSO) begin
            run_q <= rise ? cnt_t'(1) : '0;
        end else if (state_q == ESCALON || state_q == MARCHA) begin
            run_q <= inc_sat(run_q);
        end else begin
            run_q <= '0;
        end
    end

    assign limite = (run_q >= RUN_FIN);
`else
    assign limite = 1'b0;
`endif

    // Stop wins over stagger completion in the same cycle.
    assign parar = ((state_q == ESCALON) || (state_q == MARCHA)) && (!bus.arranque || limite);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= REPOSO;
            cnt_q     <= '0;
            motor1_q  <= 1'b0;
            motor2_q  <= 1'b0;
            ocupado_q <= 1'b0;
            turno_q   <= 1'b0;
            modo_q    <= MODO_ALTERNO;
        end else begin
            unique case (state_q)
                REPOSO: begin
                    if (rise) begin
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                        modo_q    <= bus.modo;
                        if (bus.modo == MODO_DUAL) begin
                            state_q  <= ESCALON;
                            motor1_q <= 1'b1;
                        end else begin
                            state_q  <= MARCHA;
                            motor1_q <= ~turno_q;
                            motor2_q <= turno_q;
                        end
                    end
                end
                ESCALON: begin
                    if (parar) begin
                        state_q  <= ENFRIA;
                        cnt_q    <= '0;
                        motor1_q <= 1'b0;
                        motor2_q <= 1'b0;
                    end else if (cnt_q == ESC_FIN) begin
                        state_q  <= MARCHA;
                        motor2_q <= 1'b1;
                    end else begin
                        cnt_q <= inc_sat(cnt_q);
                    end
                end
                MARCHA: begin
                    if (parar) begin
                        state_q  <= ENFRIA;
                        cnt_q    <= '0;
                        motor1_q <= 1'b0;
                        motor2_q <= 1'b0;
                        if (modo_q == MODO_ALTERNO) begin
                            turno_q <= ~turno_q;
                        end
                    end
                end
                ENFRIA: begin
                    motor1_q <= 1'b0;
                    motor2_q <= 1'b0;
                    if (cnt_q == ENF_FIN) begin
                        state_q   <= REPOSO;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b0;
                    end else begin
                        cnt_q <= inc_sat(cnt_q);
                    end
                end
                default: begin
                    state_q <= REPOSO;
                end
            endcase
        end
    end

    assign bus.motor1  = motor1_q;
    assign bus.motor2  = motor2_q;
    assign bus.ocupado = ocupado_q;
    assign bus.estado  = state_q;

endmodule

// File: tb/tb_controlador_motores.sv
// Directed bench for controlador_motores: a timing-based reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_controlador_motores;

    localparam int unsigned T_ESC = 4;
    localparam int unsigned T_ENF = 8;
    localparam int unsigned T_MX  = 16;
`ifdef MARCHA_MAX_EN
    localparam bit MAX_EN = 1'b1;
`else
    localparam bit MAX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    controlador_motores_if bus ();

    controlador_motores #(
        .T_ESCALON (T_ESC),
        .T_ENFRIA  (T_ENF),
        .T_MAX     (T_MX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: a run is described by its elapsed edges and the
    // remaining cool-down, not by a state register.
    bit m_run, m_dual, m_turn, m_prev, m_armed, m_a, m_rise;
    int m_elapsed, m_cool;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_dual = 0; m_turn = 0; m_prev = 0; m_armed = 0;
            m_elapsed = 0; m_cool = 0;
        end else begin
            m_a    = bus.arranque;
            m_rise = m_a && !m_prev && m_armed;
            m_prev = m_a;
            if (!m_a) m_armed = 1;
            if (m_cool > 0) begin
                m_cool--;
            end else if (m_run) begin
                m_elapsed++;
                if (!m_a || (MAX_EN && m_elapsed >= int'(T_MX))) begin
                    m_run = 0;
                    if (!m_dual) m_turn = !m_turn;
                    m_cool = T_ENF;
                end
            end else if (m_rise) begin
                m_run     = 1;
                m_elapsed = 0;
                m_dual    = bus.modo;
            end
        end
    end

    function automatic int exp_m1();
        return int'(m_run && (m_dual || !m_turn));
    endfunction

    function automatic int exp_m2();
        return int'(m_run && (m_dual ? (m_elapsed >= int'(T_ESC)) : m_turn));
    endfunction

    function automatic int exp_est();
        if (m_cool > 0) return 3;
        if (m_run) return (m_dual && m_elapsed < int'(T_ESC)) ? 1 : 2;
        return 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("model_motor1", int'(bus.motor1), exp_m1());
            check("model_motor2", int'(bus.motor2), exp_m2());
            check("model_ocupado", int'(bus.ocupado), int'(m_run || m_cool > 0));
            check("model_estado", int'(bus.estado), exp_est());
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_out(input string tag, input int m1, input int m2, input int busy,
                              input int est);
        check({tag, "_motor1"}, int'(bus.motor1), m1);
        check({tag, "_motor2"}, int'(bus.motor2), m2);
        check({tag, "_ocupado"}, int'(bus.ocupado), busy);
        check({tag, "_estado"}, int'(bus.estado), est);
    endtask

    initial begin
        bus.arranque = 1'b0;
        bus.modo     = 1'b0;
        rst          = 1'b1;
        cyc(2);
        expect_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        cyc(2);

        // Alternating runs: MOTOR1, MOTOR2, MOTOR1 with 8-cycle cool-down.
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("alt1_start", 1, 0, 1, 2);
        cyc(4);
        bus.arranque = 1'b0;
        cyc(1);
        expect_out("alt1_stop", 0, 0, 1, 3);
        cyc(7);
        check("alt1_cool_last", int'(bus.estado), 3);
        cyc(1);
        check("alt1_idle", int'(bus.estado), 0);
        cyc(1);

        bus.arranque = 1'b1;
        cyc(1);
        expect_out("alt2_start", 0, 1, 1, 2);
        cyc(4);
        bus.arranque = 1'b0;
        cyc(10);

        bus.arranque = 1'b1;
        cyc(1);
        expect_out("alt3_start", 1, 0, 1, 2);
        cyc(4);
        bus.arranque = 1'b0;
        cyc(10);

        // Dual staggered run, MODO change mid-run must be ignored.
        bus.modo     = 1'b1;
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("dual_start", 1, 0, 1, 1);
        bus.modo = 1'b0;
        cyc(3);
        check("dual_before_m2", int'(bus.motor2), 0);
        cyc(1);
        expect_out("dual_m2_on", 1, 1, 1, 2);
        cyc(15);
        bus.arranque = 1'b0;
        cyc(1);
        expect_out("dual_stop", 0, 0, 1, 3);
        cyc(10);

        // Abort during the stagger.
        bus.modo     = 1'b1;
        bus.arranque = 1'b1;
        cyc(1);
        check("abort_esc0", int'(bus.estado), 1);
        cyc(1);
        check("abort_esc1", int'(bus.estado), 1);
        bus.arranque = 1'b0;
        cyc(1);
        expect_out("abort_stop", 0, 0, 1, 3);
        cyc(7);
        check("abort_cool_last", int'(bus.estado), 3);
        cyc(1);
        check("abort_idle", int'(bus.estado), 0);
        bus.modo = 1'b0;
        cyc(2);

        // Rise during cool-down is lost; level still high does not restart.
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("turn1_start", 0, 1, 1, 2);
        cyc(2);
        bus.arranque = 1'b0;
        cyc(2);
        bus.arranque = 1'b1;
        cyc(12);
        expect_out("no_restart", 0, 0, 0, 0);
        bus.arranque = 1'b0;
        cyc(1);
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("fresh_rise", 1, 0, 1, 2);
        cyc(3);
        bus.arranque = 1'b0;
        cyc(10);

        // Asynchronous reset during a MOTOR2 run, then TURNO back to MOTOR1.
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("pre_reset", 0, 1, 1, 2);
        cyc(2);
        #2 rst = 1'b1;
        #1 expect_out("async_reset", 0, 0, 0, 0);
        @(negedge clk);
        rst          = 1'b0;
        bus.arranque = 1'b0;
        cyc(2);
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("post_reset_turn", 1, 0, 1, 2);
        cyc(3);
        bus.arranque = 1'b0;
        cyc(10);

`ifdef MARCHA_MAX_EN
        // Forced stop after T_MAX cycles with ARRANQUE held.
        bus.arranque = 1'b1;
        cyc(1);
        expect_out("max_start", 0, 1, 1, 2);
        cyc(15);
        check("max_still_on", int'(bus.motor2), 1);
        cyc(1);
        expect_out("max_forced_stop", 0, 0, 1, 3);
        cyc(23);
        expect_out("max_no_restart", 0, 0, 0, 0);
        bus.arranque = 1'b0;
        cyc(10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
